// File: rtl/egr_rrs_responder_if.sv
// ---------------------------------------------------------------------------
// egr_rrs_responder_if
//   Request / response handshake bundle between a read requestor (TQU) and
//   the egress Read Response responder.
//
//   Request channel  (requestor -> responder)
//     req_valid, req_addr, req_tag   ; req_ready back to the requestor
//   Response channel (responder -> requestor)
//     rsp_valid, rsp_data, rsp_tag, rsp_err ; rsp_ready back to the responder
//
//   Modports
//     master : requestor side
//     slave  : responder side
// ---------------------------------------------------------------------------
interface egr_rrs_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 512,
  parameter int TAG_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [TAG_W-1:0]  req_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );
endinterface

// File: rtl/egr_rrs_responder.sv
// ---------------------------------------------------------------------------
// egr_rrs_responder
//   Responder end of the egress Read Response interface. Read requests are
//   issued to a fixed-latency data-buffer read port; the returning data is
//   paired with the original tag and queued in a response FIFO so that the
//   requestor can back-pressure responses. Responses leave in acceptance
//   order. An occupancy reservation (requests in flight + responses held)
//   capped at DEPTH guarantees the FIFO never overflows.
//
// Parameters
//   ADDR_W  : request address width
//   DATA_W  : read data width
//   TAG_W   : requestor tag width (returned unmodified)
//   MEM_LAT : memory latency from mem_rd_en to mem_rd_data valid (1..8)
//   DEPTH   : response FIFO entries / max outstanding (power of two, 2..32)
//
// Ports
//   clk, rst_n   : core clock, asynchronous active-low reset
//   bus (slave)  : req_valid/req_ready/req_addr/req_tag request channel,
//                  rsp_valid/rsp_ready/rsp_data/rsp_tag/rsp_err response
//   mem_rd_en    : memory read strobe (registered)
//   mem_rd_addr  : memory read address (registered)
//   mem_rd_data  : read data, valid MEM_LAT cycles after mem_rd_en
//   mem_rd_par   : even parity over mem_rd_data
//   outstanding  : requests in flight plus responses held in the FIFO
//
// Configuration
//   EGR_RRS_PARITY_EN : when defined, parity of the returning data is checked
//                       at capture and reported on rsp_err with the response.
//                       When undefined rsp_err is tied low and mem_rd_par is
//                       ignored.
// ---------------------------------------------------------------------------
module egr_rrs_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 512,
  parameter int TAG_W   = 8,
  parameter int MEM_LAT = 3,
  parameter int DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  egr_rrs_responder_if.slave     bus,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_rd_addr,
  input  logic [DATA_W-1:0]      mem_rd_data,
  input  logic                   mem_rd_par,
  output logic [$clog2(DEPTH):0] outstanding
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0]  outstanding_r;
  logic              req_ready_s;
  logic              accept_s;
  logic              pop_s;

  logic              mem_rd_en_r;
  logic [ADDR_W-1:0] mem_rd_addr_r;

  logic [MEM_LAT:0]  dl_vld_r;
  logic [TAG_W-1:0]  dl_tag_r [MEM_LAT+1];

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              fifo_wr_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;

  logic [DATA_W-1:0] fifo_data_r [DEPTH];
  logic [TAG_W-1:0]  fifo_tag_r  [DEPTH];

  // -------------------------------------------------------------------------
  // Handshakes
  // -------------------------------------------------------------------------
  // The reservation is taken at accept time, so the FIFO slot for every
  // request already exists before its data returns from memory.
  assign req_ready_s = (outstanding_r < PTR_W'(DEPTH));
  assign accept_s    = bus.req_valid && req_ready_s;
  assign pop_s       = !fifo_empty_s && bus.rsp_ready;

  // Occupancy counter: +1 on accept, -1 on pop, unchanged when both occur.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_r <= {PTR_W{1'b0}};
    end else begin
      case ({accept_s, pop_s})
        2'b10:   outstanding_r <= outstanding_r + PTR_W'(1);
        2'b01:   outstanding_r <= outstanding_r - PTR_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Accept stage: memory read strobe and tag delay line
  // -------------------------------------------------------------------------
  // Registered memory read strobe; the address holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en_r   <= 1'b0;
      mem_rd_addr_r <= {ADDR_W{1'b0}};
    end else begin
      mem_rd_en_r <= accept_s;
      if (accept_s) begin
        mem_rd_addr_r <= bus.req_addr;
      end else begin
        mem_rd_addr_r <= mem_rd_addr_r;
      end
    end
  end

  // Tag delay line: stage 0 lines up with mem_rd_en, stage MEM_LAT with the
  // cycle in which mem_rd_data is valid. Clearing the valid bits on reset is
  // what makes data still returning from pre-reset reads harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld_r <= {(MEM_LAT+1){1'b0}};
      for (int i = 0; i <= MEM_LAT; i++) begin
        dl_tag_r[i] <= {TAG_W{1'b0}};
      end
    end else begin
      dl_vld_r    <= {dl_vld_r[MEM_LAT-1:0], accept_s};
      dl_tag_r[0] <= bus.req_tag;
      for (int i = 1; i <= MEM_LAT; i++) begin
        dl_tag_r[i] <= dl_tag_r[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Response FIFO
  // -------------------------------------------------------------------------
  assign fifo_wr_s    = dl_vld_r[MEM_LAT];
  assign wr_idx_s     = wr_ptr_r[IDX_W-1:0];
  assign rd_idx_s     = rd_ptr_r[IDX_W-1:0];
  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                        (wr_idx_s == rd_idx_s);

  // FIFO pointers with wrap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (fifo_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // FIFO payload storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (fifo_wr_s) begin
      fifo_data_r[wr_idx_s] <= mem_rd_data;
      fifo_tag_r[wr_idx_s]  <= dl_tag_r[MEM_LAT];
    end
  end

  // -------------------------------------------------------------------------
  // Response outputs (head entry, zero while empty)
  // -------------------------------------------------------------------------
  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = !fifo_empty_s;
  assign bus.rsp_data  = fifo_empty_s ? {DATA_W{1'b0}} : fifo_data_r[rd_idx_s];
  assign bus.rsp_tag   = fifo_empty_s ? {TAG_W{1'b0}}  : fifo_tag_r[rd_idx_s];

  assign mem_rd_en   = mem_rd_en_r;
  assign mem_rd_addr = mem_rd_addr_r;
  assign outstanding = outstanding_r;

`ifdef EGR_RRS_PARITY_EN
  logic fifo_err_r [DEPTH];

  // Nonzero when the data word and its even-parity bit disagree.
  function automatic logic par_err(input logic [DATA_W-1:0] data,
                                   input logic              par);
    return (^data) ^ par;
  endfunction

  // Parity error flag stored alongside each entry.
  always_ff @(posedge clk) begin
    if (fifo_wr_s) begin
      fifo_err_r[wr_idx_s] <= par_err(mem_rd_data, mem_rd_par);
    end
  end

  assign bus.rsp_err = fifo_empty_s ? 1'b0 : fifo_err_r[rd_idx_s];
`else
  logic unused_par_s;
  assign unused_par_s = mem_rd_par;
  assign bus.rsp_err  = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Design-error checks
  // -------------------------------------------------------------------------
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n)
                                   !(fifo_wr_s && fifo_full_s));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(pop_s && fifo_empty_s));
  a_occ_bound:    assert property (@(posedge clk) disable iff (!rst_n)
                                   outstanding_r <= PTR_W'(DEPTH));

endmodule

// File: tb/tb_egr_rrs_responder.sv
module tb_egr_rrs_responder;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 512;
  localparam int TAG_W   = 8;
  localparam int MEM_LAT = 3;
  localparam int DEPTH   = 8;
`ifdef EGR_RRS_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_par;
  logic [3:0]        outstanding;

  int tests;
  int fails;

  egr_rrs_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  egr_rrs_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
    .MEM_LAT(MEM_LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .mem_rd_par(mem_rd_par),
    .outstanding(outstanding)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory content: a fixed function of the address.
  function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = {a, ~a} ^ 32'h5A3C_0F96;
    return {16{w}};
  endfunction

  // Fixed-latency memory model; data outside the valid cycle is inverted so
  // a capture on the wrong cycle shows up as a data miscompare.
  logic              mp_en   [MEM_LAT];
  logic [ADDR_W-1:0] mp_addr [MEM_LAT];
  always @(posedge clk) begin
    mp_en[0]   <= mem_rd_en;
    mp_addr[0] <= mem_rd_addr;
    for (int k = 1; k < MEM_LAT; k++) begin
      mp_en[k]   <= mp_en[k-1];
      mp_addr[k] <= mp_addr[k-1];
    end
  end
  assign mem_rd_data = mp_en[MEM_LAT-1] ? mem_val(mp_addr[MEM_LAT-1])
                                        : ~mem_val(mp_addr[MEM_LAT-1]);
  // Address 0x0BAD returns with a corrupted parity bit.
  assign mem_rd_par  = (^mem_rd_data) ^ (mp_addr[MEM_LAT-1] == 16'h0BAD);

  // Drive one cycle of inputs, then return at the following falling edge.
  task automatic drive_cycle(input logic v, input logic [ADDR_W-1:0] a,
                             input logic [TAG_W-1:0] t, input logic rr);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_tag   = t;
    bus.rsp_ready = rr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = 16'h0000; bus.req_tag = 8'h00; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %0b want 1", bus.req_ready); end
    tests++; if (mem_rd_en !== 1'b0) begin fails++; $display("FAIL reset_mem_rd_en: got %0b want 0", mem_rd_en); end
    tests++; if (mem_rd_addr !== 16'h0000) begin fails++; $display("FAIL reset_mem_rd_addr: got %h want 0000", mem_rd_addr); end
    tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %0b want 0", bus.rsp_valid); end
    tests++; if (bus.rsp_data !== {DATA_W{1'b0}}) begin fails++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data[31:0]); end
    tests++; if (bus.rsp_tag !== 8'h00) begin fails++; $display("FAIL reset_rsp_tag: got %h want 00", bus.rsp_tag); end
    tests++; if (bus.rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err: got %0b want 0", bus.rsp_err); end
    tests++; if (outstanding !== 4'd0) begin fails++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    rst_n = 1'b1;
    drive_cycle(1'b0, 16'h0000, 8'h00, 1'b1);
    tests++; if (bus.req_ready !== 1'b1 || outstanding !== 4'd0) begin fails++; $display("FAIL reset_release: req_ready %0b outstanding %0d want 1/0", bus.req_ready, outstanding); end
  endtask

  task automatic test_single;
    drive_cycle(1'b1, 16'h0010, 8'h5A, 1'b1);
    tests++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 16'h0010) begin fails++; $display("FAIL single_mem_rd: en %0b addr %h want 1/0010", mem_rd_en, mem_rd_addr); end
    tests++; if (outstanding !== 4'd1) begin fails++; $display("FAIL single_outstanding_acc: got %0d want 1", outstanding); end
    for (int k = 1; k <= 4; k++) begin
      drive_cycle(1'b0, 16'h0000, 8'h00, 1'b1);
      if (k == 1) begin
        tests++; if (mem_rd_en !== 1'b0) begin fails++; $display("FAIL single_mem_rd_pulse: got %0b want 0", mem_rd_en); end
      end
      tests++; if (bus.rsp_valid !== (k == 4)) begin fails++; $display("FAIL single_latency k=%0d: rsp_valid %0b want %0b", k, bus.rsp_valid, (k == 4)); end
    end
    tests++; if (bus.rsp_tag !== 8'h5A) begin fails++; $display("FAIL single_tag: got %h want 5a", bus.rsp_tag); end
    tests++; if (bus.rsp_data !== mem_val(16'h0010)) begin fails++; $display("FAIL single_data: got %h want %h", bus.rsp_data[31:0], mem_val(16'h0010) & 512'hFFFF_FFFF); end
    tests++; if (bus.rsp_err !== 1'b0) begin fails++; $display("FAIL single_err: got %0b want 0", bus.rsp_err); end
    drive_cycle(1'b0, 16'h0000, 8'h00, 1'b1);
    tests++; if (outstanding !== 4'd0 || bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL single_drain: outstanding %0d rsp_valid %0b want 0/0", outstanding, bus.rsp_valid); end
  endtask

  task automatic test_back_to_back;
    int nrx;
    nrx = 0;
    for (int i = 0; i < 24; i++) begin
      if (i < 16) begin
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL b2b_req_ready i=%0d: got %0b want 1", i, bus.req_ready); end
      end
      drive_cycle(i < 16, 16'h0200 + 16'(i), 8'(i), 1'b1);
      tests++; if (bus.rsp_valid !== (i >= 4 && i < 20)) begin fails++; $display("FAIL b2b_rsp_valid i=%0d: got %0b want %0b", i, bus.rsp_valid, (i >= 4 && i < 20)); end
      if (i >= 4 && i < 20) begin
        nrx++;
        tests++; if (bus.rsp_tag !== 8'(i - 4)) begin fails++; $display("FAIL b2b_tag i=%0d: got %h want %h", i, bus.rsp_tag, 8'(i - 4)); end
        tests++; if (bus.rsp_data !== mem_val(16'h0200 + 16'(i - 4))) begin fails++; $display("FAIL b2b_data i=%0d: got %h", i, bus.rsp_data[31:0]); end
      end
    end
    tests++; if (nrx != 16 || outstanding !== 4'd0) begin fails++; $display("FAIL b2b_count: responses %0d outstanding %0d want 16/0", nrx, outstanding); end
  endtask

  task automatic test_full;
    int nrx;
    for (int i = 0; i < 8; i++) begin
      tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL full_req_ready i=%0d: got %0b want 1", i, bus.req_ready); end
      drive_cycle(1'b1, 16'h0300 + 16'(i), 8'h20 + 8'(i), 1'b0);
    end
    tests++; if (bus.req_ready !== 1'b0 || outstanding !== 4'd8) begin fails++; $display("FAIL full_block: req_ready %0b outstanding %0d want 0/8", bus.req_ready, outstanding); end
    repeat (6) drive_cycle(1'b1, 16'h0308, 8'h28, 1'b0);
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 8'h20) begin fails++; $display("FAIL full_head: valid %0b tag %h want 1/20", bus.rsp_valid, bus.rsp_tag); end
    tests++; if (bus.req_ready !== 1'b0 || outstanding !== 4'd8 || mem_rd_en !== 1'b0) begin fails++; $display("FAIL full_hold: req_ready %0b outstanding %0d en %0b want 0/8/0", bus.req_ready, outstanding, mem_rd_en); end
    // One-cycle pop: occupancy drops, the request is taken on the next edge.
    drive_cycle(1'b1, 16'h0308, 8'h28, 1'b1);
    tests++; if (outstanding !== 4'd7 || bus.req_ready !== 1'b1 || bus.rsp_tag !== 8'h21) begin fails++; $display("FAIL full_pop: outstanding %0d req_ready %0b tag %h want 7/1/21", outstanding, bus.req_ready, bus.rsp_tag); end
    drive_cycle(1'b1, 16'h0308, 8'h28, 1'b0);
    tests++; if (outstanding !== 4'd8 || mem_rd_en !== 1'b1 || mem_rd_addr !== 16'h0308) begin fails++; $display("FAIL full_ninth: outstanding %0d en %0b addr %h want 8/1/0308", outstanding, mem_rd_en, mem_rd_addr); end
    nrx = 1;
    for (int c = 0; c < 20; c++) begin
      if (bus.rsp_valid === 1'b1) begin
        tests++; if (bus.rsp_tag !== 8'h20 + 8'(nrx)) begin fails++; $display("FAIL full_drain_tag: got %h want %h", bus.rsp_tag, 8'h20 + 8'(nrx)); end
        tests++; if (bus.rsp_data !== mem_val(16'h0300 + 16'(nrx))) begin fails++; $display("FAIL full_drain_data n=%0d: got %h", nrx, bus.rsp_data[31:0]); end
        nrx++;
      end
      drive_cycle(1'b0, 16'h0000, 8'h00, 1'b1);
    end
    tests++; if (nrx != 9 || outstanding !== 4'd0) begin fails++; $display("FAIL full_drain_count: responses %0d outstanding %0d want 9/0", nrx, outstanding); end
  endtask

  task automatic test_alternate;
    int ntx, nrx;
    logic stalled, rr, v, acc;
    logic [DATA_W-1:0] held_data;
    logic [TAG_W-1:0]  held_tag;
    ntx = 0; nrx = 0; stalled = 1'b0;
    held_data = {DATA_W{1'b0}}; held_tag = 8'h00;
    for (int c = 0; c < 60; c++) begin
      rr = (c % 2 == 1);
      if (stalled) begin
        tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== held_tag || bus.rsp_data !== held_data) begin fails++; $display("FAIL alt_stable c=%0d: valid %0b tag %h want 1/%h", c, bus.rsp_valid, bus.rsp_tag, held_tag); end
      end
      if (bus.rsp_valid === 1'b1 && rr) begin
        tests++; if (bus.rsp_tag !== 8'h40 + 8'(nrx)) begin fails++; $display("FAIL alt_tag: got %h want %h", bus.rsp_tag, 8'h40 + 8'(nrx)); end
        tests++; if (bus.rsp_data !== mem_val(16'h0400 + 16'(nrx))) begin fails++; $display("FAIL alt_data n=%0d: got %h", nrx, bus.rsp_data[31:0]); end
        nrx++;
      end
      stalled   = (bus.rsp_valid === 1'b1) && !rr;
      held_data = bus.rsp_data;
      held_tag  = bus.rsp_tag;
      v   = (ntx < 12);
      acc = v && (bus.req_ready === 1'b1);
      drive_cycle(v, 16'h0400 + 16'(ntx), 8'h40 + 8'(ntx), rr);
      if (acc) ntx++;
    end
    tests++; if (ntx != 12 || nrx != 12) begin fails++; $display("FAIL alt_count: sent %0d received %0d want 12/12", ntx, nrx); end
    tests++; if (outstanding !== 4'd0 || bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL alt_idle: outstanding %0d valid %0b want 0/0", outstanding, bus.rsp_valid); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 16'h0500 + 16'(i), 8'h60 + 8'(i), 1'b1);
    repeat (2) drive_cycle(1'b0, 16'h0000, 8'h00, 1'b1);
    rst_n = 1'b0;
    repeat (2) drive_cycle(1'b0, 16'h0000, 8'h00, 1'b1);
    rst_n = 1'b1;
    #1;
    tests++; if (outstanding !== 4'd0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_release: outstanding %0d req_ready %0b valid %0b want 0/1/0", outstanding, bus.req_ready, bus.rsp_valid); end
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1'b0, 16'h0000, 8'h00, 1'b1);
      tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_ghost c=%0d: rsp_valid %0b want 0", c, bus.rsp_valid); end
    end
    drive_cycle(1'b1, 16'h0777, 8'h77, 1'b1);
    repeat (4) drive_cycle(1'b0, 16'h0000, 8'h00, 1'b1);
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 8'h77) begin fails++; $display("FAIL rstmid_post: valid %0b tag %h want 1/77", bus.rsp_valid, bus.rsp_tag); end
    tests++; if (bus.rsp_data !== mem_val(16'h0777)) begin fails++; $display("FAIL rstmid_post_data: got %h", bus.rsp_data[31:0]); end
    drive_cycle(1'b0, 16'h0000, 8'h00, 1'b1);
    tests++; if (outstanding !== 4'd0) begin fails++; $display("FAIL rstmid_drain: outstanding %0d want 0", outstanding); end
  endtask

  task automatic test_parity;
    logic [ADDR_W-1:0] pa [3];
    logic exp_err;
    pa[0] = 16'h0100; pa[1] = 16'h0BAD; pa[2] = 16'h0102;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(i < 3, (i < 3) ? pa[i % 3] : 16'h0000, 8'(i + 1), 1'b1);
      if (i >= 4 && i < 7) begin
        exp_err = PAR_EN && (pa[i - 4] == 16'h0BAD);
        tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== exp_err) begin fails++; $display("FAIL parity_err n=%0d: valid %0b err %0b want 1/%0b", i - 4, bus.rsp_valid, bus.rsp_err, exp_err); end
        tests++; if (bus.rsp_data !== mem_val(pa[i - 4])) begin fails++; $display("FAIL parity_data n=%0d: got %h", i - 4, bus.rsp_data[31:0]); end
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_alternate();
    test_reset_mid();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
